// File: rtl/sim_run_pkg.sv
// Shared types for the bench run controller: finish causes and FSM states.
// Monitor reporting imports the same enums so cause codes print consistently.
package sim_run_pkg;

  // Reason the run ended; NONE until the controller leaves RUN.
  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_HALT    = 3'd1,
    CAUSE_TIMEOUT = 3'd2,
    CAUSE_HANG    = 3'd3,
    CAUSE_ERROR   = 3'd4
  } cause_e;

  // Controller states: DUT held in reset, running, flushing after a failure, finished.
  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Terminal count for a counter that must fire after 'limit' cycles.
  // A zero limit maps to 0 so the compare value is always well defined;
  // callers that treat zero as "disabled" gate the compare separately.
  function automatic logic [31:0] last_count(input int unsigned limit);
    if (limit == 0) begin
      return 32'd0;
    end
    return limit - 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
// o_sat is high while the count sits at MAX; the count never wraps.
module sat_counter #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_sat
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == MAX);

  // Count register: clear has priority, then increment until MAX is reached.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_sat   = w_at_max;

endmodule

// File: rtl/sim_run_ctrl.sv
// Bench run controller: sequences the DUT reset, watches for halt, merged
// error channels, a global timeout and a forward-progress (hang) limit, and
// raises a sticky finish request with a pass/fail verdict and cause code.
//
// Finish contract: o_finish_req rises once and stays high until reset.
// o_pass, o_cause, o_err_seen and o_run_cycles are valid and stable whenever
// o_finish_req is high; the bench needs no acknowledge and may sample them on
// any cycle after it sees the request.
module sim_run_ctrl
  import sim_run_pkg::*;
#(
  parameter int          N_ERR      = 4,
  parameter int          RST_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 10000000,
  parameter int unsigned HANG_LIMIT = 100000,
  parameter int          DRAIN      = 5,
  parameter int          CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_halt,
  input  logic             i_commit,
  input  logic [N_ERR-1:0] i_err,
  output logic             o_dut_rst,
  output logic             o_running,
  output logic             o_finish_req,
  output logic             o_pass,
  output logic [2:0]       o_cause,
  output logic [N_ERR-1:0] o_err_seen,
  output logic [CNT_W-1:0] o_run_cycles,
  output logic [1:0]       o_state
);

  // Compare values. The hold/drain counter restarts at 0 on every state
  // change, so each phase ends when it reaches its own "last" value.
  localparam logic [CNT_W-1:0] LP_HOLD_LAST  = CNT_W'(last_count(RST_CYCLES));
  localparam logic [CNT_W-1:0] LP_DRAIN_LAST = CNT_W'(last_count(DRAIN));
  localparam logic [CNT_W-1:0] LP_HANG_LAST  = CNT_W'(last_count(HANG_LIMIT));
  localparam logic [CNT_W-1:0] LP_TO_LAST    = CNT_W'(last_count(TIMEOUT));
  localparam logic [CNT_W-1:0] LP_HANG_MAX   = CNT_W'(HANG_LIMIT);

  // A failure either drains first or, with no drain time, finishes at once.
  localparam state_e LP_FAIL_STATE = (DRAIN == 0) ? ST_DONE : ST_DRAIN;

  state_e           r_state;
  state_e           w_next_state;
  cause_e           r_cause;
  cause_e           w_next_cause;
  logic [N_ERR-1:0] r_err_seen;

  logic [CNT_W-1:0] w_run_cnt;
  logic [CNT_W-1:0] w_hang_cnt;
  logic [CNT_W-1:0] w_aux_cnt;
  logic             w_run_sat;
  logic             w_hang_sat;
  logic             w_aux_sat;
  logic             w_unused_sat;

  logic             w_in_run;
  logic             w_any_err;
  logic             w_hang_hit;
  logic             w_to_hit;
  logic             w_run_en;
  logic             w_hang_clr;
  logic             w_aux_clr;
  logic             w_aux_en;

  assign w_in_run  = (r_state == ST_RUN);
  assign w_any_err = |i_err;

  // Hang fires on the cycle that would make HANG_LIMIT commit-free cycles.
  assign w_hang_hit = (HANG_LIMIT != 0) && w_in_run && !i_commit &&
                      (w_hang_cnt == LP_HANG_LAST);
  // Timeout fires on run cycle TIMEOUT-1, i.e. after TIMEOUT cycles in RUN.
  assign w_to_hit   = (TIMEOUT != 0) && w_in_run && (w_run_cnt == LP_TO_LAST);

  // Next-state and cause selection; inside RUN the priority is
  // ERROR > HALT > HANG > TIMEOUT.
  always_comb begin
    w_next_state = r_state;
    w_next_cause = r_cause;
    case (r_state)
      ST_HOLD: begin
        if (w_aux_cnt == LP_HOLD_LAST) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_any_err) begin
          w_next_cause = CAUSE_ERROR;
          w_next_state = LP_FAIL_STATE;
        end else if (i_halt) begin
          w_next_cause = CAUSE_HALT;
          w_next_state = ST_DONE;
        end else if (w_hang_hit) begin
          w_next_cause = CAUSE_HANG;
          w_next_state = LP_FAIL_STATE;
        end else if (w_to_hit) begin
          w_next_cause = CAUSE_TIMEOUT;
          w_next_state = LP_FAIL_STATE;
        end
      end
      ST_DRAIN: begin
        if (w_aux_cnt == LP_DRAIN_LAST) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_DONE;
      end
      default: begin
        w_next_state = ST_HOLD;
      end
    endcase
  end

  // State, cause and sticky error capture; errors count only in RUN/DRAIN
  // because the memory and monitor models are still settling during HOLD.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_HOLD;
      r_cause    <= CAUSE_NONE;
      r_err_seen <= '0;
    end else begin
      r_state <= w_next_state;
      r_cause <= w_next_cause;
      if ((r_state == ST_RUN) || (r_state == ST_DRAIN)) begin
        r_err_seen <= r_err_seen | i_err;
      end
    end
  end

  // run_cycles advances only on cycles that stay in RUN, so at finish it
  // reports the run cycle on which the ending event was taken.
  assign w_run_en   = w_in_run && (w_next_state == ST_RUN);
  // The hang counter is held at 0 outside RUN and on every retired instruction.
  assign w_hang_clr = !w_in_run || i_commit;
  // One counter serves both HOLD and DRAIN; it restarts on each state change.
  assign w_aux_clr  = (w_next_state != r_state);
  assign w_aux_en   = (r_state == ST_HOLD) || (r_state == ST_DRAIN);

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_run_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (1'b0),
    .i_en    (w_run_en),
    .o_count (w_run_cnt),
    .o_sat   (w_run_sat)
  );

  sat_counter #(
    .WIDTH (CNT_W),
    .MAX   (LP_HANG_MAX)
  ) u_hang_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_hang_clr),
    .i_en    (w_in_run),
    .o_count (w_hang_cnt),
    .o_sat   (w_hang_sat)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_aux_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_aux_clr),
    .i_en    (w_aux_en),
    .o_count (w_aux_cnt),
    .o_sat   (w_aux_sat)
  );

  // Saturation flags are not needed for control here: the compares above end
  // each phase before any counter can reach its ceiling.
  assign w_unused_sat = w_run_sat ^ w_hang_sat ^ w_aux_sat;

  // All outputs decode registered state only, so nothing combinational runs
  // from the rst release or from halt/err to the bench.
  assign o_dut_rst    = (r_state == ST_HOLD);
  assign o_running    = (r_state == ST_RUN);
  assign o_finish_req = (r_state == ST_DONE);
  assign o_pass       = (r_state == ST_DONE) && (r_cause == CAUSE_HALT) &&
                        (r_err_seen == '0);
  assign o_cause      = r_cause;
  assign o_err_seen   = r_err_seen;
  assign o_run_cycles = w_run_cnt;
  assign o_state      = r_state;

endmodule
